// File: rtl/planar_fetch_scheduler_if.sv
// DDR read-port bundle between the planar fetch scheduler and the DDR controller.
//
// Handshake: the master raises ddr_read together with ddr_acquire, ddr_addr,
// ddr_burstcnt and target. The request is accepted in the first cycle in which
// ddr_busy is low; ddr_read falls after that cycle. The slave then returns
// exactly ddr_burstcnt words, one per cycle in which ddr_rdata_ready is high.
// ddr_acquire stays high until the last word has been returned.
interface planar_fetch_scheduler_if #(
    parameter int CHROMA_PLANES = 2
);
    logic                   ddr_busy;
    logic                   ddr_rdata_ready;
    logic                   ddr_read;
    logic                   ddr_acquire;
    logic [28:0]            ddr_addr;
    logic [7:0]             ddr_burstcnt;
    logic [CHROMA_PLANES:0] target;

    modport master (
        input  ddr_busy, ddr_rdata_ready,
        output ddr_read, ddr_acquire, ddr_addr, ddr_burstcnt, target
    );

    modport slave (
        output ddr_busy, ddr_rdata_ready,
        input  ddr_read, ddr_acquire, ddr_addr, ddr_burstcnt, target
    );
endinterface

// File: rtl/planar_fetch_scheduler.sv
// DDR read scheduler for planar YUV playback: per-line chroma bursts for each
// chroma plane (lowest plane index first), luma bursts on FIFO demand, end of
// frame tracking and a clean drain of in-flight words on abort.
module planar_fetch_scheduler #(
    parameter int         ADDR_W        = 29,
    parameter int         CHROMA_PLANES = 2,
    parameter int         Y_BURST       = 50,
    parameter logic [3:0] DDR_CORE_BASE = 4'b0011
) (
    input  logic                            clkddr,
    input  logic                            reset_n,
    input  logic                            frame_start,
    input  logic                            abort,
    input  logic [ADDR_W-1:0]               y_base,
    input  logic [CHROMA_PLANES*ADDR_W-1:0] c_base,
    input  logic [8:0]                      frame_width,
    input  logic [8:0]                      frame_height,
    input  logic                            chroma_vsub,
    input  logic                            line_start,
    input  logic                            y_half_empty,
    planar_fetch_scheduler_if.master        bus,
    output logic                            frame_active,
    output logic                            y_done,
    output logic [1:0]                      dbg_state,
    output logic [8:0]                      dbg_line_count
);

    localparam int TW = CHROMA_PLANES + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                   state;
    logic [1:0]               rst_sync;
    logic                     rst_n;
    logic                     read_q;
    logic                     acq_q;
    logic [28:0]              addr_q;
    logic [7:0]               burst_q;
    logic [TW-1:0]            target_q;
    logic [ADDR_W-1:0]        y_addr;
    logic [ADDR_W-1:0]        c_addr [CHROMA_PLANES];
    logic [CHROMA_PLANES-1:0] c_flag;
    logic [15:0]              y_rem;
    logic [7:0]               word_cnt;
    logic [7:0]               width_half;
    logic                     vsub_q;
    logic [8:0]               chroma_lines;
    logic [8:0]               line_cnt;
    logic                     phase;
    logic                     sel_luma;
    logic [1:0]               sel_idx;

    logic                     pick_c;
    logic [1:0]               pick_idx;
    logic [ADDR_W-1:0]        c_sel_addr;
    logic [ADDR_W-1:0]        issue_addr;
    logic [7:0]               y_len;
    logic [7:0]               c_burst;
    logic [17:0]              pix;
    logic                     last_word;
    logic                     chroma_done;
    logic                     start_take;
    logic                     unused_bits;

    // Reset asserts asynchronously; release is retimed through two flops.
    always_ff @(posedge clkddr or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Lowest-index chroma plane still waiting for its line, and its address.
    always_comb begin
        pick_c     = 1'b0;
        pick_idx   = 2'd0;
        c_sel_addr = '0;
        for (int k = CHROMA_PLANES - 1; k >= 0; k--) begin
            if (!c_flag[k]) begin
                pick_c   = 1'b1;
                pick_idx = 2'(k);
            end
        end
        for (int k = 0; k < CHROMA_PLANES; k++) begin
            if (2'(k) == pick_idx) c_sel_addr = c_addr[k];
        end
    end

    // Burst sizing, word accounting and frame completion terms.
    always_comb begin
        y_len       = (y_rem < 16'(Y_BURST)) ? y_rem[7:0] : 8'(Y_BURST);
        c_burst     = {3'b000, width_half[7:3]};
        pix         = 18'(frame_width) * 18'(frame_height);
        issue_addr  = pick_c ? c_sel_addr : y_addr;
        last_word   = (word_cnt == 8'd0) || ((word_cnt == 8'd1) && bus.ddr_rdata_ready);
        chroma_done = (line_cnt >= chroma_lines) && (&c_flag);
        start_take  = (state == IDLE) && frame_start && !abort;
    end

    assign unused_bits = ^{issue_addr, pix[2:0]};

    // Scheduler FSM with all bus-side outputs registered.
    always_ff @(posedge clkddr or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            read_q       <= 1'b0;
            acq_q        <= 1'b0;
            addr_q       <= '0;
            burst_q      <= '0;
            target_q     <= '0;
            frame_active <= 1'b0;
            y_done       <= 1'b0;
            y_addr       <= '0;
            for (int k = 0; k < CHROMA_PLANES; k++) c_addr[k] <= '0;
            c_flag       <= '1;
            y_rem        <= '0;
            word_cnt     <= '0;
            width_half   <= '0;
            vsub_q       <= 1'b0;
            chroma_lines <= '0;
            line_cnt     <= '0;
            phase        <= 1'b0;
            sel_luma     <= 1'b0;
            sel_idx      <= '0;
        end else begin
            if (read_q && !bus.ddr_busy) read_q <= 1'b0;
            if (bus.ddr_rdata_ready && (word_cnt != 8'd0)) word_cnt <= word_cnt - 8'd1;

            case (state)
                IDLE: begin
                    if (abort) begin
                        frame_active <= 1'b0;
                        state        <= DRAIN;
                    end else if (frame_start) begin
                        y_addr <= y_base;
                        for (int k = 0; k < CHROMA_PLANES; k++) c_addr[k] <= c_base[k*ADDR_W +: ADDR_W];
                        width_half   <= frame_width[8:1];
                        vsub_q       <= chroma_vsub;
                        chroma_lines <= chroma_vsub ? {1'b0, frame_height[8:1]} : frame_height;
                        y_rem        <= 16'(pix[17:3]);
                        y_done       <= 1'b0;
                        c_flag       <= '0;
                        line_cnt     <= '0;
                        phase        <= 1'b0;
                        frame_active <= 1'b1;
                    end else if (frame_active) begin
                        if (pick_c) begin
                            if (c_burst == 8'd0) begin
                                // Line too narrow to carry chroma: mark it fetched.
                                for (int k = 0; k < CHROMA_PLANES; k++)
                                    if (2'(k) == pick_idx) c_flag[k] <= 1'b1;
                            end else begin
                                read_q   <= 1'b1;
                                acq_q    <= 1'b1;
                                addr_q   <= {DDR_CORE_BASE, issue_addr[27:3]};
                                burst_q  <= c_burst;
                                target_q <= TW'(2) << pick_idx;
                                word_cnt <= c_burst;
                                sel_luma <= 1'b0;
                                sel_idx  <= pick_idx;
                                state    <= ISSUE;
                            end
                        end else if (y_half_empty && !y_done) begin
                            read_q   <= 1'b1;
                            acq_q    <= 1'b1;
                            addr_q   <= {DDR_CORE_BASE, issue_addr[27:3]};
                            burst_q  <= y_len;
                            target_q <= TW'(1);
                            word_cnt <= y_len;
                            sel_luma <= 1'b1;
                            state    <= ISSUE;
                        end else if (y_done && chroma_done) begin
                            frame_active <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    // The request is on the bus, so its bookkeeping stands even on abort.
                    if (sel_luma) begin
                        y_addr <= y_addr + ADDR_W'({burst_q, 3'b000});
                        y_rem  <= y_rem - 16'(burst_q);
                        if (y_rem == 16'(burst_q)) y_done <= 1'b1;
                    end else begin
                        for (int k = 0; k < CHROMA_PLANES; k++) begin
                            if (2'(k) == sel_idx) begin
                                c_addr[k] <= c_addr[k] + ADDR_W'(width_half);
                                c_flag[k] <= 1'b1;
                            end
                        end
                    end
                    if (abort) begin
                        frame_active <= 1'b0;
                        target_q     <= '0;
                        state        <= DRAIN;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        frame_active <= 1'b0;
                        target_q     <= '0;
                        state        <= DRAIN;
                    end else if (last_word) begin
                        acq_q    <= 1'b0;
                        target_q <= '0;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (last_word) begin
                        acq_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Line pacing; placed last so a clear beats a same-cycle flag set.
            if (line_start && frame_active && !start_take && (line_cnt < chroma_lines)) begin
                phase <= ~phase;
                if (!vsub_q || phase) begin
                    c_flag   <= '0;
                    line_cnt <= line_cnt + 9'd1;
                end
            end
        end
    end

    assign bus.ddr_read     = read_q;
    assign bus.ddr_acquire  = acq_q;
    assign bus.ddr_addr     = addr_q;
    assign bus.ddr_burstcnt = burst_q;
    assign bus.target       = target_q;
    assign dbg_state        = state;
    assign dbg_line_count   = line_cnt;

endmodule

// File: doc/planar_fetch_scheduler.md
# planar_fetch_scheduler

Parametrised DDR read scheduler for planar YUV frame playback in the FMV path, running entirely in the `clkddr` domain. It fetches per-line chroma bursts for N chroma planes and streams luma in fixed bursts on FIFO demand. It supports 4:2:0 and 4:2:2 vertical chroma subsampling, tracks end of frame, and drains cleanly on abort. Its `target` output routes `ddr_rdata` write enables into the luma FIFO and the chroma line buffers downstream.

## Interface
- `ADDR_W`, 29: byte-address width of plane bases.
- `CHROMA_PLANES`, 2: number of chroma planes, 1..3; chroma priority follows plane index order.
- `Y_BURST`, 50: luma burst length in 64-bit words.
- `DDR_CORE_BASE`, 4'b0011: top nibble forced onto `ddr_addr`.

- `clkddr` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; latches bases, geometry and mode, and arms the frame.
- `abort` in 1: level; while high, no new request is issued.
- `y_base` in ADDR_W: luma plane byte base.
- `c_base` in CHROMA_PLANES*ADDR_W: chroma plane byte bases.
- `frame_width` in 9: luma pixels per line, multiple of 16.
- `frame_height` in 9: luma lines.
- `chroma_vsub` in 1: 1 = 4:2:0, 0 = 4:2:2.
- `line_start` in 1: one-cycle pulse at the start of each displayed line.
- `y_half_empty` in 1: luma FIFO demand.
- `ddr_busy` in 1: DDR controller busy.
- `ddr_rdata_ready` in 1: one read word valid.
- `ddr_read` out 1: read request.
- `ddr_acquire` out 1: bus ownership.
- `ddr_addr` out 29: `{DDR_CORE_BASE, addr[27:3]}`.
- `ddr_burstcnt` out 8: burst length in words.
- `target` out 1+CHROMA_PLANES: one-hot destination; bit 0 = luma, bit k = chroma plane k-1.
- `frame_active` out 1: frame armed and not finished or aborted.
- `y_done` out 1: all luma for the frame requested.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- Reset: all outputs 0; state IDLE; all counters 0; all requested flags set.
- `frame_start`, accepted only in IDLE with `abort` low:
  - latch every input field;
  - clear all chroma-requested flags and clear `y_done`;
  - set `frame_active`;
  - `y_remaining = frame_width*frame_height/8` words;
  - `chroma_lines = chroma_vsub ? height/2 : height`.
- IDLE with `frame_active`: pick the lowest-index chroma plane whose flag is clear; otherwise pick luma if `y_half_empty && !y_done`; otherwise stay in IDLE.
- ISSUE (one cycle), driving `ddr_read`, `ddr_acquire`, `ddr_addr`, `ddr_burstcnt`, `target` and the word counter, then entering WAIT:
  - chroma: burst = `frame_width/16`; plane address += `frame_width/2`; set the plane's flag.
  - luma: burst = min(`Y_BURST`, `y_remaining`); address += 8*burst; `y_remaining` -= burst; `y_done` is set when the result is 0.
- `ddr_read` drops in the first cycle with `ddr_busy` low, ISSUE cycle included.
- Word counter decrements on each `ddr_rdata_ready` and saturates at 0; extra words are ignored and `target` stays 0 for them.
- WAIT → IDLE when the counter reaches 0; `ddr_acquire` and `target` clear in that same cycle.
- `line_start` handling, only while `frame_active` and line count < `chroma_lines`:
  - 4:2:2: every pulse clears all chroma flags and increments the line count.
  - 4:2:0: a phase bit toggles on every pulse; flags clear and the line count increments only on pulses where the phase was 1.
- `frame_active` clears when `y_done` is set, all chroma lines are fetched, and the state is IDLE.
- `abort` in IDLE or ISSUE: clear `frame_active`, go to DRAIN (a request already on the bus still counts).
- `abort` in WAIT: `target` clears immediately, go to DRAIN.
- DRAIN: consume remaining words with `target` = 0, then drop `ddr_acquire` and go to IDLE.
- `frame_start` during abort or DRAIN is ignored.
- `frame_width` < 16: chroma flags are set without issuing a request.
- `line_start` in the same cycle as an ISSUE of chroma: the flag is cleared, so the line is re-requested afterwards.

## Timing
- `frame_start` at cycle t → ISSUE at t+2 (IDLE evaluation at t+1).
- Back-to-back bursts: the last data word at t → IDLE at t+1 → next ISSUE at t+2.
- No combinational path from any input to `ddr_read` or `ddr_addr`; every output is registered.
- Async assert of `reset_n` clears everything without a clock edge; the deasserting edge is synchronised internally with a 2-flop synchroniser.

## Test plan
- Width 320, 4:2:2, two planes, `y_half_empty` high: U burst 20 words at `c_base0`, then V burst 20 words, then luma bursts of 50 words; the U address advances by 160 bytes per line.
- 4:2:0, four `line_start` pulses: exactly two chroma refetch pairs (after pulses 2 and 4); the line count reads 2.
- Width 32, height 2: `y_remaining` = 8, so a single luma burst of 8 words is issued; `y_done` = 1; `frame_active` clears once chroma lines finish.
- `abort` mid-burst after 10 of 50 words: `target` reads 0 for the remaining 40 words; `ddr_acquire` drops after word 50; a `frame_start` sent during that drain is ignored.
- `ddr_busy` held high for 5 cycles after ISSUE: `ddr_read` stays high for 5 cycles and drops on the first low cycle.
- `reset_n` pulsed low asynchronously during WAIT: all outputs read 0 immediately; the first `frame_start` after reset issues a request at +2 cycles.
